// File: rtl/exe_stage.sv
// Execute stage: operand-2 generation, ALU with NZCV flags, branch target adder,
// and the EXE/MEM pipeline register.
module exe_stage (
   input  logic        clk,
   input  logic        rst,
   input  logic        stall,
   input  logic        exe_WB_EN,
   input  logic        exe_MEM_R_EN,
   input  logic        exe_MEM_W_EN,
   input  logic        immediate,
   input  logic [3:0]  exe_EXE_CMD,
   input  logic        exe_B,
   input  logic        exe_S,
   input  logic [31:0] PC,
   input  logic [31:0] exe_Val_Rn,
   input  logic [31:0] exe_Val_Rm,
   input  logic [7:0]  exe_immed_8,
   input  logic [3:0]  exe_rotate_imm,
   input  logic [23:0] exe_Signed_imm_24,
   input  logic [3:0]  exe_Dest,
   output logic        branch_taken,
   output logic [31:0] branch_addr,
   output logic [31:0] status_reg,
   output logic        mem_WB_EN,
   output logic        mem_MEM_R_EN,
   output logic        mem_MEM_W_EN,
   output logic [31:0] mem_ALU_res,
   output logic [31:0] mem_Val_Rm,
   output logic [3:0]  mem_Dest
);

   logic [3:0]  nzcv_q, nzcv_d;
   logic [11:0] so;
   logic [4:0]  sh;
   logic [31:0] val2;
   logic [31:0] res;
   logic [32:0] wide;
   logic        cin, c_flag, v_flag;

   function automatic logic [31:0] ror32(input logic [31:0] x, input logic [4:0] a);
      // A shift by 32 yields zero, so a==0 returns x unchanged.
      return (x >> a) | (x << (6'd32 - {1'b0, a}));
   endfunction

   assign so  = {exe_rotate_imm, exe_immed_8};
   assign sh  = so[11:7];
   assign cin = nzcv_q[1];

   always_comb begin
      val2 = '0;
      if (exe_MEM_R_EN | exe_MEM_W_EN) begin
         val2 = {20'b0, so};
      end else if (immediate) begin
         val2 = ror32({24'b0, exe_immed_8}, {exe_rotate_imm, 1'b0});
      end else begin
         case (so[6:5])
            2'b00:   val2 = exe_Val_Rm << sh;
            2'b01:   val2 = exe_Val_Rm >> sh;
            2'b10:   val2 = $unsigned($signed(exe_Val_Rm) >>> sh);
            default: val2 = ror32(exe_Val_Rm, sh);
         endcase
      end
   end

   always_comb begin
      wide   = '0;
      res    = '0;
      c_flag = cin;
      v_flag = nzcv_q[0];
      case (exe_EXE_CMD)
         4'b0001: res = val2;
         4'b1001: res = ~val2;
         4'b0010, 4'b0011: begin
            wide   = {1'b0, exe_Val_Rn} + {1'b0, val2}
                   + {32'b0, (exe_EXE_CMD[0] & cin)};
            res    = wide[31:0];
            c_flag = wide[32];
            v_flag = (exe_Val_Rn[31] == val2[31]) && (res[31] != exe_Val_Rn[31]);
         end
         4'b0100, 4'b0101: begin
            wide   = {1'b0, exe_Val_Rn} - {1'b0, val2}
                   - {32'b0, (exe_EXE_CMD[0] & ~cin)};
            res    = wide[31:0];
            c_flag = ~wide[32];
            v_flag = (exe_Val_Rn[31] != val2[31]) && (res[31] != exe_Val_Rn[31]);
         end
         4'b0110: res = exe_Val_Rn & val2;
         4'b0111: res = exe_Val_Rn | val2;
         4'b1000: res = exe_Val_Rn ^ val2;
         default: res = '0;
      endcase
      nzcv_d = {res[31], (res == 32'b0), c_flag, v_flag};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         nzcv_q       <= '0;
         mem_WB_EN    <= 1'b0;
         mem_MEM_R_EN <= 1'b0;
         mem_MEM_W_EN <= 1'b0;
         mem_ALU_res  <= '0;
         mem_Val_Rm   <= '0;
         mem_Dest     <= '0;
      end else if (!stall) begin
         if (exe_S) nzcv_q <= nzcv_d;
         mem_WB_EN    <= exe_WB_EN;
         mem_MEM_R_EN <= exe_MEM_R_EN;
         mem_MEM_W_EN <= exe_MEM_W_EN;
         mem_ALU_res  <= res;
         mem_Val_Rm   <= exe_Val_Rm;
         mem_Dest     <= exe_Dest;
      end
   end

   assign status_reg   = {nzcv_q, 28'b0};
   assign branch_taken = exe_B & ~stall;
   assign branch_addr  = PC + {{6{exe_Signed_imm_24[23]}}, exe_Signed_imm_24, 2'b00};

endmodule
